// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to packed-BCD converter, one bit per clock.
// Optional leading-zero mask on blank is built only when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int          IN_W    = 14,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic [15:0]     bcd,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [3:0]      blank
);

    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IN_W-1:0] r_bin;
    logic [15:0]     r_scratch;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic [15:0]     r_bcd;
    logic            r_done;
    logic            r_ovf_out;

    logic            w_load;
    logic            w_shift;
    logic            w_finish;
    logic            w_busy;
    logic            w_ovf_in;
    logic [IN_W-1:0] w_bin_sat;
    logic [15:0]     w_adj;
    logic [3:0]      w_blank;

    // Saturate out-of-range inputs so every digit stays within 0..9.
    assign w_ovf_in  = 32'(bin) > MAX_VAL;
    assign w_bin_sat = w_ovf_in ? IN_W'(MAX_VAL) : bin;

    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < 4; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy  = 1'b1;
                w_shift = 1'b1;
                if (r_cnt == CW'(1))
                    w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                w_busy      = 1'b1;
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef BIN2BCD_BLANK_EN
    logic w_z3;
    logic w_z2;
    logic w_z1;
    logic [3:0] r_blank;

    assign w_z3    = r_scratch[15:12] == 4'd0;
    assign w_z2    = w_z3 && (r_scratch[11:8] == 4'd0);
    assign w_z1    = w_z2 && (r_scratch[7:4] == 4'd0);
    assign w_blank = {w_z3, w_z2, w_z1, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_blank <= 4'd0;
        else if (w_finish)
            r_blank <= w_blank;
    end

    assign blank = r_blank;
`else
    assign w_blank = 4'd0;
    assign blank   = w_blank;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_scratch <= 16'd0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_bcd     <= 16'd0;
            r_done    <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;
            if (w_load) begin
                r_bin     <= w_bin_sat;
                r_scratch <= 16'd0;
                r_cnt     <= CW'(IN_W);
                r_ovf     <= w_ovf_in;
            end
            if (w_shift) begin
                r_scratch <= {w_adj[14:0], r_bin[IN_W-1]};
                r_bin     <= r_bin << 1;
                r_cnt     <= r_cnt - CW'(1);
            end
            if (w_finish) begin
                r_bcd     <= r_scratch;
                r_ovf_out <= r_ovf;
            end
        end
    end

    assign bcd      = r_bcd;
    assign busy     = w_busy;
    assign done     = r_done;
    assign overflow = r_ovf_out;

endmodule
